bus_mem_page: RTL and testbench
===============================

Name: bus_mem_page

Overview:
Parametrised memory-page slave for the multiplexed processor bus. Each transfer carries an upper address beat, then a lower address beat, then data. The block decodes its page ID from the top address bits and services single or burst reads/writes into local storage. It extends the fixed 8-bit single-beat page with configurable width, depth, read latency, burst transfers and an optional abort timeout. Multiple instances with distinct PAGE_ID share one bus.

Parameters:
DW, 8, bus/data width; full address is 2*DW bits (upper beat, then lower beat)
PAGE_BITS, 2, number of top address bits used as page select
PAGE_ID, 1, page this instance answers to (0 .. 2^PAGE_BITS-1)
MEM_AW, 14, implemented word-address bits; must be ≤ 2*DW-PAGE_BITS; depth = 2^MEM_AW
READ_LAT, 1, cycles from lower-address edge to first read beat (≥1)
BURST_LEN, 4, beats per burst transfer (≥2)
MAX_WAIT, 0, idle cycles tolerated mid-transfer before abort; 0 = unbounded

Ports:
b_Clock  in  1  bus clock, all state on rising edge
b_Reset_L  in  1  asynchronous, active-low reset
b_addrValid_L  in  1  low = address beat on b_dataIn
b_rw  in  1  sampled with upper beat; 1 = read, 0 = write
b_burst  in  1  sampled with upper beat; 1 = BURST_LEN beats
b_dataIn  in  DW  address/write-data from master
b_mDValid_L  in  1  low = write-data beat valid
b_dataOut  out  DW  read data, registered
b_dataOE  out  1  high while this slave drives read data
b_sDValid_L  out  1  low = read-data beat valid
abort  out  1  one-cycle pulse on timeout or protocol restart
rd_count  out  16  completed read beats (BUS_MEM_STATS_EN only)
wr_count  out  16  completed write beats (BUS_MEM_STATS_EN only)

Behaviour:
- Reset (async, any state): state=IDLE; b_dataOut=0, b_dataOE=0, b_sDValid_L=1, abort=0, counters=0. Memory contents are not cleared.
- States: IDLE, ADDR_LO, SKIP_LO, WR_DATA, RD_WAIT, RD_DATA.
- IDLE: on b_addrValid_L=0, latch upper beat, b_rw and b_burst. If page field == PAGE_ID, go to ADDR_LO; otherwise go to SKIP_LO.
- SKIP_LO: the next b_addrValid_L=0 is consumed as a foreign lower beat; return to IDLE. The block never drives the bus for a foreign page. If b_rw=1, also ignore that transfer's data phase (stay IDLE; do not decode read beats).
- ADDR_LO: wait for b_addrValid_L=0, then latch the lower beat. Word address = low MEM_AW bits of {upper,lower}. Go to WR_DATA (write) or RD_WAIT (read). Zero-delay back-to-back beats are legal.
- WR_DATA: each cycle with b_mDValid_L=0 writes b_dataIn at the current address and post-increments the address. Transfer ends after 1 beat (single) or BURST_LEN beats (burst), then IDLE. A data beat on the cycle right after the lower beat is legal.
- RD_WAIT: count READ_LAT-1 cycles. First beat is valid (b_sDValid_L=0, b_dataOE=1, b_dataOut=mem[addr]) in the cycle starting READ_LAT edges after the lower-address edge.
- RD_DATA: beats are consecutive, one per cycle, address increments; after the last beat, deassert OE/valid and go to IDLE.
- Address increment wraps modulo 2^MEM_AW, staying within the page.
- Timeout: when MAX_WAIT>0, the idle-cycle counter in ADDR_LO/WR_DATA resets on every valid beat. Reaching MAX_WAIT pulses abort and returns to IDLE. Writes already done are kept.
- b_addrValid_L=0 during WR_DATA/RD_WAIT/RD_DATA is a protocol violation: pulse abort, drop outputs the next cycle, and treat the beat as a new upper beat.
- b_mDValid_L is ignored outside WR_DATA.

Optional Feature:
BUS_MEM_STATS_EN defined: rd_count/wr_count increment once per completed read/write beat, saturating at 16'hFFFF, reset to 0.
Not defined: both ports are tied to 0 and no counter logic is present.

Test Plan:
1. Defaults, PAGE_ID=1: write 0x7F11←0xAB, 0x7F22←0xCD, 0x7E11←0xEF; read each back -> 0xAB/0xCD/0xEF, with b_sDValid_L low exactly 1 cycle after the lower edge.
2. Write 0xBF11←0xCD (page 2), then read 0xBF11 and 0x7F11 -> b_dataOE stays 0 during the page-2 transfer; 0x7F11 returns 0xAB.
3. Zero delay: upper/lower/data on consecutive cycles, 0x7F11←0x43 then 0x7E11←0x78; read 0x7F11 -> 0x43.
4. 20 idle cycles between upper and lower beats: MAX_WAIT=0 -> write completes, readback correct. MAX_WAIT=8 -> abort pulses on the 8th idle cycle, no write, next transfer works.
5. Burst write at 0x7FFE of 0x01..0x04 -> stored at 0x7FFE, 0x7FFF, 0x4000, 0x4001 (wrap); burst read from 0x7FFE returns 4 consecutive beats 01,02,03,04; counters (if enabled) = 4/4.
6. Assert b_Reset_L low mid read burst (beat 2) -> OE and valid drop immediately, state IDLE; a later read of 0x7FFE still returns 0x01.

Source files
------------

// File: rtl/bus_mem_page.sv
// Memory-page slave on the multiplexed bus: upper beat, lower beat, then single or burst data.
// Latency: first read beat is valid READ_LAT edges after the lower-address edge; writes land on the data-beat edge.
// Backpressure: none; the master paces beats and this slave aborts after MAX_WAIT idle cycles. Optional: BUS_MEM_STATS_EN.
module bus_mem_page #(
  parameter int DW        = 8,
  parameter int PAGE_BITS = 2,
  parameter int PAGE_ID   = 1,
  parameter int MEM_AW    = 14,
  parameter int READ_LAT  = 1,
  parameter int BURST_LEN = 4,
  parameter int MAX_WAIT  = 0
) (
  input  logic          b_Clock,
  input  logic          b_Reset_L,
  input  logic          b_addrValid_L,
  input  logic          b_rw,
  input  logic          b_burst,
  input  logic [DW-1:0] b_dataIn,
  input  logic          b_mDValid_L,
  output logic [DW-1:0] b_dataOut,
  output logic          b_dataOE,
  output logic          b_sDValid_L,
  output logic          abort,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);

  localparam int UW = (MEM_AW > DW) ? MEM_AW - DW : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [2:0] {IDLE, ADDR_LO, SKIP_LO, WR_DATA, RD_WAIT, RD_DATA} state_t;

  state_t              state_q, state_d;
  logic [UW-1:0]       upper_q;
  logic                rw_q, burst_q;
  logic [MEM_AW-1:0]   addr_q, lo_addr;
  logic [BW-1:0]       beat_q, beat_total;
  logic [LW-1:0]       lat_q;
  logic [WW-1:0]       wait_q;
  logic [DW-1:0]       mem [2**MEM_AW];

  logic addr_beat, data_beat, page_hit, restart, wait_hit;
  logic latch_hi, latch_lo, wr_en, rd_load, rd_drop, abort_d;

  assign addr_beat  = !b_addrValid_L;
  assign data_beat  = !b_mDValid_L;
  assign page_hit   = (b_dataIn[DW-1 -: PAGE_BITS] == PAGE_BITS'(PAGE_ID));
  assign beat_total = burst_q ? BW'(BURST_LEN) : BW'(1);
  assign wait_hit   = (MAX_WAIT > 0) && (wait_q == WW'(MAX_WAIT - 1));
  // An address beat while a data phase is in flight restarts the transfer
  assign restart    = addr_beat && (state_q == WR_DATA || state_q == RD_WAIT || state_q == RD_DATA);

  // Word address: low MEM_AW bits of {upper, lower}
  generate
    if (MEM_AW > DW) begin : g_wide
      assign lo_addr = {upper_q, b_dataIn};
    end else begin : g_narrow
      assign lo_addr = b_dataIn[MEM_AW-1:0];
    end
  endgenerate

  // State register
  always_ff @(posedge b_Clock or negedge b_Reset_L) begin
    if (!b_Reset_L) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_d  = state_q;
    latch_hi = 1'b0;
    latch_lo = 1'b0;
    wr_en    = 1'b0;
    rd_load  = 1'b0;
    rd_drop  = 1'b0;
    abort_d  = 1'b0;
    if (restart) begin
      abort_d  = 1'b1;
      rd_drop  = 1'b1;
      latch_hi = 1'b1;
      state_d  = page_hit ? ADDR_LO : SKIP_LO;
    end else begin
      case (state_q)
        IDLE: if (addr_beat) begin
          latch_hi = 1'b1;
          state_d  = page_hit ? ADDR_LO : SKIP_LO;
        end
        // Foreign lower beat; foreign data phases are never decoded
        SKIP_LO: if (addr_beat) state_d = IDLE;
        ADDR_LO: if (addr_beat) begin
          latch_lo = 1'b1;
          state_d  = rw_q ? RD_WAIT : WR_DATA;
        end else if (wait_hit) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end
        WR_DATA: if (data_beat) begin
          wr_en = 1'b1;
          if (beat_q == beat_total - BW'(1)) state_d = IDLE;
        end else if (wait_hit) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end
        RD_WAIT: if (lat_q == LW'(READ_LAT - 1)) begin
          rd_load = 1'b1;
          state_d = RD_DATA;
        end
        RD_DATA: if (beat_q == beat_total) begin
          rd_drop = 1'b1;
          state_d = IDLE;
        end else begin
          rd_load = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Transfer context, counters and registered read outputs
  always_ff @(posedge b_Clock or negedge b_Reset_L) begin
    if (!b_Reset_L) begin
      upper_q     <= '0;
      rw_q        <= 1'b0;
      burst_q     <= 1'b0;
      addr_q      <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      wait_q      <= '0;
      b_dataOut   <= '0;
      b_dataOE    <= 1'b0;
      b_sDValid_L <= 1'b1;
      abort       <= 1'b0;
    end else begin
      abort <= abort_d;
      if (latch_hi) begin
        upper_q <= b_dataIn[UW-1:0];
        rw_q    <= b_rw;
        burst_q <= b_burst;
      end
      if (latch_lo) begin
        addr_q <= lo_addr;
        beat_q <= '0;
        lat_q  <= '0;
      end
      if (latch_hi || latch_lo || wr_en) wait_q <= '0;
      else if (state_q == ADDR_LO || state_q == WR_DATA) wait_q <= wait_q + WW'(1);
      if (state_q == RD_WAIT && !rd_load && !restart) lat_q <= lat_q + LW'(1);
      // Address wraps modulo the implemented depth, staying inside the page
      if (wr_en || rd_load) begin
        addr_q <= addr_q + MEM_AW'(1);
        beat_q <= beat_q + BW'(1);
      end
      if (rd_load) begin
        b_dataOut   <= mem[addr_q];
        b_dataOE    <= 1'b1;
        b_sDValid_L <= 1'b0;
      end else if (rd_drop) begin
        b_dataOut   <= '0;
        b_dataOE    <= 1'b0;
        b_sDValid_L <= 1'b1;
      end
    end
  end

  // Local storage; reset leaves contents intact
  always_ff @(posedge b_Clock) begin
    if (wr_en) mem[addr_q] <= b_dataIn;
  end

`ifdef BUS_MEM_STATS_EN
  // Saturating beat counters
  always_ff @(posedge b_Clock or negedge b_Reset_L) begin
    if (!b_Reset_L) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_load && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (wr_en && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_bus_mem_page.sv
// Directed bench for bus_mem_page: two page-1 instances share the bus, the second with MAX_WAIT=8.
// Inputs are driven 1ns after the rising edge; registered outputs are sampled at the same point.
// The second instance's address-valid can be masked to model a master that abandons after abort.
module tb_bus_mem_page;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        av_n = 1'b1, rw = 1'b0, burst = 1'b0, mdv_n = 1'b1, mask2 = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout, dout2;
  logic        oe, oe2, sdv_n, sdv2_n, abort, abort2;
  logic [15:0] rdc, wrc, rdc2, wrc2;
  logic        av2_n;

  int checks = 0, errors = 0;
  int exp_rd = 0, exp_wr = 0;
  int ab_first, ab_cnt;
  logic ab1_seen;
  logic [7:0] last2;

  always #5 clk = ~clk;
  assign av2_n = av_n | mask2;

  bus_mem_page dut (
    .b_Clock(clk), .b_Reset_L(rst_n), .b_addrValid_L(av_n), .b_rw(rw), .b_burst(burst),
    .b_dataIn(din), .b_mDValid_L(mdv_n), .b_dataOut(dout), .b_dataOE(oe), .b_sDValid_L(sdv_n),
    .abort(abort), .rd_count(rdc), .wr_count(wrc)
  );

  bus_mem_page #(.MAX_WAIT(8)) dut2 (
    .b_Clock(clk), .b_Reset_L(rst_n), .b_addrValid_L(av2_n), .b_rw(rw), .b_burst(burst),
    .b_dataIn(din), .b_mDValid_L(mdv_n), .b_dataOut(dout2), .b_dataOE(oe2), .b_sDValid_L(sdv2_n),
    .abort(abort2), .rd_count(rdc2), .wr_count(wrc2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write transfer; beat i of n comes from dv[8*(n-1-i) +: 8]
  task automatic wr(input logic [15:0] a, input logic [31:0] dv, input logic bst,
                    input int gap, input logic msk);
    int n;
    n = bst ? 4 : 1;
    av_n = 1'b0; din = a[15:8]; rw = 1'b0; burst = bst;
    tick();
    av_n = 1'b1;
    ab_first = 0; ab_cnt = 0; ab1_seen = 1'b0;
    for (int i = 1; i <= gap; i++) begin
      tick();
      if (abort2) begin
        ab_cnt++;
        if (ab_first == 0) ab_first = i;
      end
      if (abort) ab1_seen = 1'b1;
    end
    mask2 = msk;
    av_n = 1'b0; din = a[7:0];
    tick();
    av_n = 1'b1; mask2 = 1'b0;
    for (int i = 0; i < n; i++) begin
      mdv_n = 1'b0; din = dv[8*(n-1-i) +: 8];
      tick();
    end
    mdv_n = 1'b1;
    if (a[15:14] == 2'b01) exp_wr += n;
  endtask

  // Read transfer; checks valid timing, OE, each beat and release afterwards
  task automatic rd(input logic [15:0] a, input logic bst, input logic [31:0] ev, input string tag);
    int n;
    n = bst ? 4 : 1;
    av_n = 1'b0; din = a[15:8]; rw = 1'b1; burst = bst;
    tick();
    din = a[7:0];
    tick();
    av_n = 1'b1; rw = 1'b0; burst = 1'b0;
    check({tag, "_early"}, 16'(sdv_n), 16'h1);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_vld"}, 16'(sdv_n), 16'h0);
      check({tag, "_oe"}, 16'(oe), 16'h1);
      check({tag, "_dat"}, 16'(dout), 16'(ev[8*(n-1-i) +: 8]));
      if (i == 0) last2 = dout2;
    end
    tick();
    check({tag, "_end"}, 16'({oe, sdv_n}), 16'h1);
    exp_rd += n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_dout", 16'(dout), 16'h0);
    check("rst_oe", 16'(oe), 16'h0);
    check("rst_sdv", 16'(sdv_n), 16'h1);
    check("rst_abort", 16'(abort), 16'h0);
    check("rst_rdc", rdc, 16'h0);
    check("rst_wrc", wrc, 16'h0);
    rst_n = 1'b1;
    tick();

    // 1: basic single writes and reads
    wr(16'h7F11, 32'hAB, 1'b0, 1, 1'b0);
    wr(16'h7F22, 32'hCD, 1'b0, 1, 1'b0);
    wr(16'h7E11, 32'hEF, 1'b0, 1, 1'b0);
    rd(16'h7F11, 1'b0, 32'hAB, "t1_7f11");
    rd(16'h7F22, 1'b0, 32'hCD, "t1_7f22");
    rd(16'h7E11, 1'b0, 32'hEF, "t1_7e11");

    // 2: foreign page is ignored and never driven
    wr(16'hBF11, 32'hCD, 1'b0, 0, 1'b0);
    av_n = 1'b0; din = 8'hBF; rw = 1'b1;
    tick();
    din = 8'h11;
    tick();
    av_n = 1'b1; rw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_foreign_oe", 16'({oe, oe2}), 16'h0);
      tick();
    end
    rd(16'h7F11, 1'b0, 32'hAB, "t2_7f11");

    // 3: zero-delay beats, back to back
    wr(16'h7F11, 32'h43, 1'b0, 0, 1'b0);
    wr(16'h7E11, 32'h78, 1'b0, 0, 1'b0);
    rd(16'h7F11, 1'b0, 32'h43, "t3_7f11");
    rd(16'h7E11, 1'b0, 32'h78, "t3_7e11");

    // 4: 20 idle cycles between address beats
    wr(16'h7D05, 32'h11, 1'b0, 0, 1'b0);
    wr(16'h7D05, 32'h22, 1'b0, 20, 1'b1);
    check("t4_abort_cycle", 16'(ab_first), 16'd8);
    check("t4_abort_pulses", 16'(ab_cnt), 16'd1);
    check("t4_unbounded_no_abort", 16'(ab1_seen), 16'h0);
    rd(16'h7D05, 1'b0, 32'h22, "t4_unbounded");
    check("t4_timeout_nowrite", 16'(last2), 16'h11);

    // 5: burst write across the page wrap, singles and burst readback
    wr(16'h7FFE, 32'h01020304, 1'b1, 0, 1'b0);
    rd(16'h7FFF, 1'b0, 32'h02, "t5_7fff");
    rd(16'h4000, 1'b0, 32'h03, "t5_4000");
    rd(16'h4001, 1'b0, 32'h04, "t5_4001");
    rd(16'h7FFE, 1'b1, 32'h01020304, "t5_burst");
`ifdef BUS_MEM_STATS_EN
    check("t5_rdc", rdc, 16'(exp_rd));
    check("t5_wrc", wrc, 16'(exp_wr));
`else
    check("t5_rdc", rdc, 16'h0);
    check("t5_wrc", wrc, 16'h0);
`endif

    // 6: reset in the middle of a burst read
    av_n = 1'b0; din = 8'h7F; rw = 1'b1; burst = 1'b1;
    tick();
    din = 8'hFE;
    tick();
    av_n = 1'b1; rw = 1'b0; burst = 1'b0;
    tick();
    tick();
    check("t6_beat2", 16'(dout), 16'h02);
    rst_n = 1'b0;
    #1;
    check("t6_rst_oe", 16'(oe), 16'h0);
    check("t6_rst_sdv", 16'(sdv_n), 16'h1);
    exp_rd = 0; exp_wr = 0;
    tick();
    rst_n = 1'b1;
    tick();
    rd(16'h7FFE, 1'b0, 32'h01, "t6_after");
`ifdef BUS_MEM_STATS_EN
    check("t6_rdc", rdc, 16'(exp_rd));
    check("t6_wrc", wrc, 16'(exp_wr));
`else
    check("t6_rdc", rdc, 16'h0);
    check("t6_wrc", wrc, 16'h0);
`endif
    check("t6_abort", 16'(abort), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
